// File: rtl/pupil_pkg.sv
// Shared constants, slot layout helpers and line-capture state encoding for the
// camera line packer and the pupil detector that consumes its line bus.
package pupil_pkg;

    localparam int MAX_RESOLUTION = 112;
    localparam int PIX_W          = 8;
    localparam int SLOT_W         = PIX_W + 1;
    localparam int BUS_W          = MAX_RESOLUTION * SLOT_W + 1;
    localparam int SLOT_IDX_W     = $clog2(MAX_RESOLUTION);
    localparam int CNT_W          = 8;
    localparam int LINE_READY_BIT = 0;

    localparam logic [CNT_W-1:0] MAX_RES_CNT = CNT_W'(MAX_RESOLUTION);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_CAPTURE,
        ST_PUBLISH
    } line_state_t;

    // Lowest bus bit of pixel slot k; bit 0 of the bus is the line-ready flag.
    function automatic int slot_lsb(input int k);
        return SLOT_W * k + 1;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers the camera frame/line strobes once and derives single-cycle
// rise/fall pulses from the registered copies.
module cam_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic frame_valid,
    input  logic line_valid,
    output logic line_level,
    output logic frame_rise,
    output logic frame_fall,
    output logic line_rise,
    output logic line_fall
);

    logic fv_q, fv_d;
    logic lv_q, lv_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fv_q <= 1'b0;
            fv_d <= 1'b0;
            lv_q <= 1'b0;
            lv_d <= 1'b0;
        end else begin
            fv_q <= frame_valid;
            fv_d <= fv_q;
            lv_q <= line_valid;
            lv_d <= lv_q;
        end
    end

    assign line_level = lv_q;
    assign frame_rise = fv_q & ~fv_d;
    assign frame_fall = ~fv_q & fv_d;
    assign line_rise  = lv_q & ~lv_d;
    assign line_fall  = ~lv_q & lv_d;

endmodule

// File: rtl/cam_line_packer.sv
// Packs one camera line into a working buffer and publishes it atomically on
// img_buf_newline. Define HBIN2_EN for 2:1 horizontal binning of pixel pairs.
module cam_line_packer
    import pupil_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             frame_valid,
    input  logic             line_valid,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic [BUS_W-1:0] img_buf_newline,
    output logic             frame_capture_start,
    output logic             line_done,
    output logic [CNT_W-1:0] line_count,
    output logic [CNT_W-1:0] line_width,
    output logic             overrun
);

    logic lv_lvl, fv_rise, fv_fall, lv_rise, lv_fall;

    cam_sync_edge u_sync (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_valid (frame_valid),
        .line_valid  (line_valid),
        .line_level  (lv_lvl),
        .frame_rise  (fv_rise),
        .frame_fall  (fv_fall),
        .line_rise   (lv_rise),
        .line_fall   (lv_fall)
    );

    logic             pv_q;
    logic [PIX_W-1:0] pd_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pv_q <= 1'b0;
            pd_q <= '0;
        end else begin
            pv_q <= pix_valid;
            pd_q <= pix_data;
        end
    end

    line_state_t state, state_nxt;

    logic [PIX_W-1:0]      wbuf [MAX_RESOLUTION];
    logic [PIX_W-1:0]      last_pix;
    logic [CNT_W-1:0]      wr_idx;
    logic [CNT_W-1:0]      line_len;
    logic [CNT_W-1:0]      idx_cur;
    logic [SLOT_IDX_W-1:0] wr_ptr;

    logic frame_go, publish_go, line_start, capturing, pix_take, take_ovf;

`ifdef HBIN2_EN
    logic [PIX_W-1:0] half_pix;
    logic             have_half;
    logic             half_cur;
    logic [PIX_W:0]   pair_sum;
    logic [PIX_W-1:0] pair_avg;

    assign pair_sum = {1'b0, half_pix} + {1'b0, pd_q};
    assign pair_avg = PIX_W'(pair_sum >> 1);
    assign half_cur = line_start ? 1'b0 : have_half;
    // A pending odd pixel already sits in slot wr_idx, so it counts as a slot.
    assign line_len = wr_idx + CNT_W'(have_half);
`else
    assign line_len = wr_idx;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (fv_rise) state_nxt = ST_FRAME;
            end
            ST_FRAME: begin
                if (fv_fall)      state_nxt = ST_IDLE;
                else if (lv_rise) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (fv_fall)      state_nxt = ST_IDLE;
                else if (lv_fall) state_nxt = (line_len != '0) ? ST_PUBLISH : ST_FRAME;
            end
            ST_PUBLISH: begin
                if (fv_fall)      state_nxt = ST_IDLE;
                else if (lv_rise) state_nxt = ST_CAPTURE;
                else              state_nxt = ST_FRAME;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A line that starts while leaving FRAME/PUBLISH captures its first pixel
    // in that same cycle, so back-to-back lines lose nothing.
    always_comb begin
        frame_go   = (state == ST_IDLE) && fv_rise;
        publish_go = (state == ST_CAPTURE) && !fv_fall && lv_fall && (line_len != '0);
        line_start = ((state == ST_FRAME) || (state == ST_PUBLISH)) && !fv_fall && lv_rise;
        capturing  = (state == ST_CAPTURE) || line_start;
        pix_take   = capturing && lv_lvl && pv_q;
        idx_cur    = line_start ? '0 : wr_idx;
        take_ovf   = pix_take && (idx_cur == MAX_RES_CNT);
        wr_ptr     = idx_cur[SLOT_IDX_W-1:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx   <= '0;
            last_pix <= '0;
            for (int unsigned k = 0; k < MAX_RESOLUTION; k++) wbuf[k] <= '0;
`ifdef HBIN2_EN
            half_pix  <= '0;
            have_half <= 1'b0;
`endif
        end else if (pix_take && !take_ovf) begin
`ifdef HBIN2_EN
            if (half_cur) begin
                wbuf[wr_ptr] <= pair_avg;
                last_pix     <= pair_avg;
                wr_idx       <= idx_cur + CNT_W'(1);
                have_half    <= 1'b0;
            end else begin
                wbuf[wr_ptr] <= pd_q;
                last_pix     <= pd_q;
                half_pix     <= pd_q;
                have_half    <= 1'b1;
                wr_idx       <= idx_cur;
            end
`else
            wbuf[wr_ptr] <= pd_q;
            last_pix     <= pd_q;
            wr_idx       <= idx_cur + CNT_W'(1);
`endif
        end else if (!capturing || line_start) begin
            wr_idx <= '0;
`ifdef HBIN2_EN
            have_half <= 1'b0;
`endif
        end
    end

    logic [PIX_W-1:0] out_slot [MAX_RESOLUTION];
    logic             line_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_capture_start <= 1'b0;
            line_done           <= 1'b0;
            line_ready          <= 1'b0;
            line_count          <= '0;
            line_width          <= '0;
            overrun             <= 1'b0;
            for (int unsigned k = 0; k < MAX_RESOLUTION; k++) out_slot[k] <= '0;
        end else begin
            frame_capture_start <= frame_go;
            line_done           <= publish_go;
            if (frame_go) begin
                line_ready <= 1'b0;
                line_count <= '0;
                overrun    <= 1'b0;
            end else begin
                if (take_ovf) overrun <= 1'b1;
                if (publish_go) begin
                    // Unfilled tail slots repeat the last pixel to avoid a false edge.
                    for (int unsigned k = 0; k < MAX_RESOLUTION; k++)
                        out_slot[k] <= (CNT_W'(k) < line_len) ? wbuf[k] : last_pix;
                    line_ready <= 1'b1;
                    line_width <= line_len;
                    if (line_count != '1) line_count <= line_count + CNT_W'(1);
                end
            end
        end
    end

    assign img_buf_newline[LINE_READY_BIT] = line_ready;

    for (genvar g = 0; g < MAX_RESOLUTION; g++) begin : g_slot
        assign img_buf_newline[slot_lsb(g) +: SLOT_W] = {{(SLOT_W-PIX_W){1'b0}}, out_slot[g]};
    end

endmodule

// File: tb/tb_cam_line_packer.sv
// Directed bench for cam_line_packer: reset, frame start, full/short/long
// lines, back-to-back lines, aborted line and mid-capture reset.
module tb_cam_line_packer;
    import pupil_pkg::*;

    logic             clock;
    logic             reset_n;
    logic             frame_valid;
    logic             line_valid;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic [BUS_W-1:0] img_buf_newline;
    logic             frame_capture_start;
    logic             line_done;
    logic [7:0]       line_count;
    logic [7:0]       line_width;
    logic             overrun;

    cam_line_packer dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .frame_valid         (frame_valid),
        .line_valid          (line_valid),
        .pix_valid           (pix_valid),
        .pix_data            (pix_data),
        .img_buf_newline     (img_buf_newline),
        .frame_capture_start (frame_capture_start),
        .line_done           (line_done),
        .line_count          (line_count),
        .line_width          (line_width),
        .overrun             (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pix_arr [0:255];
    logic [8:0] exp_slot [0:111];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] slot_of(input int k);
        return img_buf_newline[9*k+1 +: 9];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            line_valid = 1'b1;
            pix_valid  = 1'b1;
            pix_data   = pix_arr[i];
            tick();
        end
        pix_valid = 1'b0;
    endtask

    // Drop line_valid; a publish must show exactly two cycles later.
    task automatic finish_line(input string tag, input logic expect_pub);
        line_valid = 1'b0;
        pix_valid  = 1'b0;
        tick();
        check_eq({tag, "_done_early"}, 32'(line_done), 32'd0);
        tick();
        check_eq({tag, "_done"}, 32'(line_done), 32'(expect_pub));
    endtask

    task automatic set_exp(input int n);
        for (int k = 0; k < 112; k++)
            exp_slot[k] = (k < n) ? {1'b0, pix_arr[k]} : {1'b0, pix_arr[n-1]};
    endtask

    task automatic check_all_slots(input string tag);
        for (int k = 0; k < 112; k++)
            check_eq($sformatf("%s_slot%0d", tag, k), 32'(slot_of(k)), 32'(exp_slot[k]));
    endtask

    task automatic start_frame(input string tag);
        frame_valid = 1'b1;
        tick();
        check_eq({tag, "_fcs_early"}, 32'(frame_capture_start), 32'd0);
        tick();
        check_eq({tag, "_fcs"}, 32'(frame_capture_start), 32'd1);
    endtask

    logic seen;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; frame_valid = 1'b0; line_valid = 1'b0;
        pix_valid = 1'b0; pix_data = '0;
        repeat (3) tick();
        check_eq("rst_bus", 32'(|img_buf_newline), 32'd0);
        check_eq("rst_fcs", 32'(frame_capture_start), 32'd0);
        check_eq("rst_done", 32'(line_done), 32'd0);
        check_eq("rst_count", 32'(line_count), 32'd0);
        check_eq("rst_width", 32'(line_width), 32'd0);
        check_eq("rst_ovr", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        start_frame("f1");
        tick();
        check_eq("f1_fcs_pulse", 32'(frame_capture_start), 32'd0);

`ifdef HBIN2_EN
        pix_arr[0] = 8'd10; pix_arr[1] = 8'd20; pix_arr[2] = 8'd255; pix_arr[3] = 8'd254;
        for (int k = 4; k < 256; k++) pix_arr[k] = 8'(k >> 1);
        drive_pixels(224);
        finish_line("b1", 1'b1);
        for (int k = 0; k < 112; k++) exp_slot[k] = 9'(k);
        exp_slot[0] = 9'd15;
        exp_slot[1] = 9'd254;
        check_all_slots("b1");
        check_eq("b1_width", 32'(line_width), 32'd112);
        check_eq("b1_ovr", 32'(overrun), 32'd0);
        check_eq("b1_count", 32'(line_count), 32'd1);
        check_eq("b1_ready", 32'(img_buf_newline[0]), 32'd1);
        repeat (3) tick();

        pix_arr[0] = 8'd10; pix_arr[1] = 8'd20; pix_arr[2] = 8'd30;
        pix_arr[3] = 8'd40; pix_arr[4] = 8'd77;
        drive_pixels(5);
        finish_line("b2", 1'b1);
        for (int k = 0; k < 112; k++) exp_slot[k] = 9'd77;
        exp_slot[0] = 9'd15;
        exp_slot[1] = 9'd35;
        check_all_slots("b2");
        check_eq("b2_width", 32'(line_width), 32'd3);
        check_eq("b2_ovr", 32'(overrun), 32'd0);
        repeat (3) tick();

        for (int k = 0; k < 256; k++) pix_arr[k] = 8'(k >> 1);
        drive_pixels(226);
        finish_line("b3", 1'b1);
        check_eq("b3_width", 32'(line_width), 32'd112);
        check_eq("b3_ovr", 32'(overrun), 32'd1);
        check_eq("b3_count", 32'(line_count), 32'd3);
`else
        for (int k = 0; k < 256; k++) pix_arr[k] = 8'(k * 2);
        drive_pixels(112);
        finish_line("l1", 1'b1);
        set_exp(112);
        check_all_slots("l1");
        check_eq("l1_ready", 32'(img_buf_newline[0]), 32'd1);
        check_eq("l1_count", 32'(line_count), 32'd1);
        check_eq("l1_width", 32'(line_width), 32'd112);
        check_eq("l1_ovr", 32'(overrun), 32'd0);
        tick();
        check_eq("l1_done_pulse", 32'(line_done), 32'd0);

        // Stray pixels with line_valid low must not land anywhere.
        pix_valid = 1'b1; pix_data = 8'hFF;
        repeat (3) tick();
        pix_valid = 1'b0;
        tick();

        for (int k = 0; k < 39; k++) pix_arr[k] = 8'(8'h90 + k);
        pix_arr[39] = 8'h37;
        drive_pixels(40);
        finish_line("l2", 1'b1);
        set_exp(40);
        check_all_slots("l2");
        check_eq("l2_width", 32'(line_width), 32'd40);
        check_eq("l2_count", 32'(line_count), 32'd2);
        repeat (3) tick();

        for (int k = 0; k < 256; k++) pix_arr[k] = 8'(k + 1);
        drive_pixels(130);
        finish_line("l3", 1'b1);
        set_exp(112);
        check_all_slots("l3");
        check_eq("l3_ovr", 32'(overrun), 32'd1);
        check_eq("l3_width", 32'(line_width), 32'd112);
        check_eq("l3_count", 32'(line_count), 32'd3);
        repeat (3) tick();

        // Next line rises during the PUBLISH cycle of the previous one.
        for (int k = 0; k < 256; k++) pix_arr[k] = 8'd5;
        drive_pixels(10);
        line_valid = 1'b0;
        tick();
        check_eq("l4_done_early", 32'(line_done), 32'd0);
        line_valid = 1'b1; pix_valid = 1'b1; pix_data = 8'd9;
        tick();
        check_eq("l4_done", 32'(line_done), 32'd1);
        check_eq("l4_width", 32'(line_width), 32'd10);
        check_eq("l4_slot0", 32'(slot_of(0)), 32'h005);
        pix_data = 8'd8;
        tick();
        pix_data = 8'd7;
        tick();
        finish_line("l5", 1'b1);
        pix_arr[0] = 8'd9; pix_arr[1] = 8'd8; pix_arr[2] = 8'd7;
        set_exp(3);
        check_all_slots("l5");
        check_eq("l5_width", 32'(line_width), 32'd3);
        check_eq("l5_count", 32'(line_count), 32'd5);
        check_eq("l5_ovr_sticky", 32'(overrun), 32'd1);
        repeat (3) tick();

        for (int k = 0; k < 256; k++) pix_arr[k] = 8'hAA;
        drive_pixels(60);
        frame_valid = 1'b0;
        pix_valid   = 1'b1;
        seen        = 1'b0;
        repeat (3) begin
            tick();
            seen |= line_done;
        end
        line_valid = 1'b0; pix_valid = 1'b0;
        repeat (5) begin
            tick();
            seen |= line_done;
        end
        check_eq("abort_no_done", 32'(seen), 32'd0);
        check_eq("abort_count", 32'(line_count), 32'd5);
        check_eq("abort_ready", 32'(img_buf_newline[0]), 32'd1);
        check_eq("abort_ovr", 32'(overrun), 32'd1);
        check_all_slots("abort");

        start_frame("f2");
        check_eq("f2_ovr_clr", 32'(overrun), 32'd0);
        check_eq("f2_ready_clr", 32'(img_buf_newline[0]), 32'd0);
        check_eq("f2_count_clr", 32'(line_count), 32'd0);
        check_all_slots("f2_keep");
        repeat (2) tick();

        line_valid = 1'b1;
        repeat (2) tick();
        finish_line("empty", 1'b0);
        check_eq("empty_count", 32'(line_count), 32'd0);
        check_eq("empty_ready", 32'(img_buf_newline[0]), 32'd0);
        repeat (2) tick();
`endif

        for (int k = 0; k < 256; k++) pix_arr[k] = 8'h11;
        drive_pixels(50);
        pix_valid = 1'b1;
        reset_n   = 1'b0;
        #1;
        check_eq("mrst_bus", 32'(|img_buf_newline), 32'd0);
        check_eq("mrst_count", 32'(line_count), 32'd0);
        check_eq("mrst_width", 32'(line_width), 32'd0);
        check_eq("mrst_ovr", 32'(overrun), 32'd0);
        check_eq("mrst_done", 32'(line_done), 32'd0);
        frame_valid = 1'b0; line_valid = 1'b0; pix_valid = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check_eq("mrst_ready", 32'(img_buf_newline[0]), 32'd0);
        seen = 1'b0;
        line_valid = 1'b1; pix_valid = 1'b1; pix_data = 8'h22;
        repeat (5) begin
            tick();
            seen |= line_done | frame_capture_start;
        end
        line_valid = 1'b0; pix_valid = 1'b0;
        repeat (4) begin
            tick();
            seen |= line_done | frame_capture_start;
        end
        check_eq("mrst_idle", 32'(seen), 32'd0);
        check_eq("mrst_count_idle", 32'(line_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_line_packer.md
Name: cam_line_packer

Overview:
- Producer side of the `img_buf_newline` / `frame_capture_start` interface consumed by the pupil detector.
- Samples the inward-facing camera's parallel pixel stream (frame_valid / line_valid / pix_valid / 8-bit gray).
- Packs one line into a working buffer, then publishes it atomically into the flattened line bus with a line-complete flag.
- Double-buffered: the consumer always sees a stable, complete line.

Parameters:
- MAX_RESOLUTION, 112, pixel slots per published line.
- PIX_W, 8, camera grayscale width.
- SLOT_W, 9, bits per pixel slot (PIX_W plus one guard bit).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_valid  in  1  camera frame strobe (high for the whole frame).
- line_valid  in  1  camera line strobe (high for the whole line).
- pix_valid  in  1  pix_data valid this cycle; ignored unless line_valid=1.
- pix_data  in  PIX_W  grayscale pixel, 0=black, 255=white.
- img_buf_newline  out  MAX_RESOLUTION*SLOT_W+1  published line; pixel k in bits [SLOT_W*(k+1) : SLOT_W*k+1] as {1'b0, pix}; bit 0 = line_ready flag.
- frame_capture_start  out  1  one-cycle pulse at frame start.
- line_done  out  1  one-cycle pulse on each publish.
- line_count  out  8  lines published in the current frame.
- line_width  out  8  pixels received in the last published line, saturating at MAX_RESOLUTION.
- overrun  out  1  sticky per frame: some line carried more than MAX_RESOLUTION pixels.

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs 0, including every slot and bit 0; line_count=0.
  - Working buffer cleared; state IDLE.
- Inputs registered once; edges detected on the registered copies.
- States:
  - IDLE: wait for frame_valid rise → FRAME.
  - FRAME: line_valid rise → CAPTURE; frame_valid fall → IDLE.
  - CAPTURE: each pix_valid writes pix_data to slot wr_idx, wr_idx++.
    - line_valid fall → PUBLISH.
    - frame_valid fall before line_valid fall → abort: no publish, → IDLE.
  - PUBLISH: one cycle, then → FRAME.
- Frame start:
  - frame_capture_start pulses 1 cycle after frame_valid rise is registered.
  - Same cycle: bit 0 cleared, line_count=0, overrun=0.
  - Slot data keeps its last value.
- PUBLISH cycle (registered):
  - Copy working buffer to img_buf_newline.
  - Set bit 0; pulse line_done.
  - line_count++ (saturates at 255); line_width=min(wr_idx, MAX_RESOLUTION).
- Output latency: published data appears 2 cycles after line_valid falls at the pin.
- Short line (wr_idx<MAX_RESOLUTION):
  - Slots wr_idx..MAX_RESOLUTION-1 are filled with the last received pixel, so padding creates no false edge.
  - wr_idx=0: line is not published and line_count does not increment.
- Long line: pixels beyond slot MAX_RESOLUTION-1 are dropped and overrun is set.
- Slot guard bit (MSB) is always 0.
- Bit 0 stays high between publishes; the next publish overwrites all slots in one cycle, so there is no tearing.
- pix_valid while line_valid=0 is ignored.
- line_valid rise while in PUBLISH is held and honoured the next cycle (→ CAPTURE); no pixel is lost.
- wr_idx is 8-bit and stops incrementing at MAX_RESOLUTION.

Optional Feature:
- Macro: HBIN2_EN.
- Defined: 2:1 horizontal binning.
  - Pixel pairs are averaged, slot = (a+b)>>1 with a 9-bit sum.
  - An odd trailing pixel is stored unaveraged.
  - A 224-pixel sensor line fills 112 slots; overrun is evaluated on binned count.
  - line_width reports binned pixels.
- Undefined: one pixel per slot, no averaging logic.

Decomposition:
- Shared package (pupil_pkg):
  - MAX_RESOLUTION, SLOT_W, PIX_W.
  - Slot index helper constants.
  - State encoding for IDLE/FRAME/CAPTURE/PUBLISH.
  - Also used by the pupil detector.
- Sub-module: cam_sync_edge (input registering plus rise/fall pulse generation for frame_valid and line_valid).
- Pixel packing stays in the top level.

Test Plan:
- Reset mid-CAPTURE (reset_n low after 50 pixels) → all outputs 0 immediately; after release, bit 0=0 and state IDLE.
- Frame rise, then line of 112 pixels valued k*2 → frame_capture_start one pulse.
  - After line_valid falls: slot k = {0, 2k}, bit 0=1, line_done pulse, line_count=1, line_width=112, overrun=0.
- Line of 40 pixels, last = 0x37 → slots 0..39 data; slots 40..111 = 0x037; line_width=40.
- Line of 130 pixels → slots 0..111 hold first 112; overrun=1 until the next frame rise, then clears to 0.
- frame_valid falls mid-line after 60 pixels → no line_done, img_buf_newline unchanged, line_count unchanged.
- HBIN2_EN build, pairs (10,20),(255,254) → slot0=15, slot1=254; 224 pixels → line_width=112, overrun=0.
